// File: rtl/dvsd_cmp_pkg.sv
// Shared types and sizing helpers for the iterative magnitude comparator.
package dvsd_cmp_pkg;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  typedef enum logic [1:0] {RES_LT, RES_EQ, RES_GT} res_t;

  function automatic int unsigned nchunk_f(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

  function automatic int unsigned idx_w_f(input int unsigned nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/dvsd_cmp_chunk.sv
// Combinational CHUNK-bit unsigned magnitude compare.
module dvsd_cmp_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_lt_c,
  output logic             o_eq_c,
  output logic             o_gt_c
);

  assign o_lt_c = (i_a < i_b);
  assign o_eq_c = (i_a == i_b);
  assign o_gt_c = (i_a > i_b);

endmodule

// File: rtl/dvsd_cmp_iter.sv
// Multi-cycle signed/unsigned magnitude comparator, CHUNK bits per clock, MSB first.
// Macro DVSD_CMP_EARLY_EXIT_EN: finish on the first differing chunk instead of a fixed NCHUNK steps.
module dvsd_cmp_iter
  import dvsd_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             less_than,
  output logic             equal_to,
  output logic             greater_than
);

  localparam int unsigned NCHUNK = nchunk_f(WIDTH, CHUNK);
  localparam int unsigned IW     = idx_w_f(NCHUNK);

  generate
    if ((CHUNK == 0) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $error("dvsd_cmp_iter: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic             r_in_ready, w_in_ready_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_lt, r_eq, r_gt;
  logic             w_lt_nxt, w_eq_nxt, w_gt_nxt;
`ifndef DVSD_CMP_EARLY_EXIT_EN
  logic             r_found, w_found_nxt;
  res_t             r_res, w_res_nxt;
`endif

  logic [CHUNK-1:0] w_a_chunks [NCHUNK];
  logic [CHUNK-1:0] w_b_chunks [NCHUNK];
  logic [CHUNK-1:0] w_a_sel, w_b_sel;
  logic             w_lt, w_eq, w_gt;
  res_t             w_res_cur, w_res_fin;
  logic [WIDTH-1:0] w_sign_flip;

  genvar g;
  generate
    for (g = 0; g < NCHUNK; g++) begin : g_chunks
      assign w_a_chunks[g] = r_a[g*CHUNK +: CHUNK];
      assign w_b_chunks[g] = r_b[g*CHUNK +: CHUNK];
    end
  endgenerate

  assign w_a_sel = w_a_chunks[r_idx];
  assign w_b_sel = w_b_chunks[r_idx];

  dvsd_cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_a    (w_a_sel),
    .i_b    (w_b_sel),
    .o_lt_c (w_lt),
    .o_eq_c (w_eq),
    .o_gt_c (w_gt)
  );

  // Flipping both MSBs maps two's-complement order onto unsigned order.
  assign w_sign_flip = WIDTH'(signed_mode) << (WIDTH - 1);

  assign w_res_cur = w_lt ? RES_LT : (w_gt ? RES_GT : RES_EQ);
`ifdef DVSD_CMP_EARLY_EXIT_EN
  assign w_res_fin = w_res_cur;
`else
  assign w_res_fin = r_found ? r_res : w_res_cur;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_idx_nxt       = r_idx;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_lt_nxt        = r_lt;
    w_eq_nxt        = r_eq;
    w_gt_nxt        = r_gt;
`ifndef DVSD_CMP_EARLY_EXIT_EN
    w_found_nxt     = r_found;
    w_res_nxt       = r_res;
`endif
    unique case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_a_nxt        = A_in ^ w_sign_flip;
          w_b_nxt        = B_in ^ w_sign_flip;
          w_idx_nxt      = IW'(NCHUNK - 1);
          w_in_ready_nxt = 1'b0;
          w_state_nxt    = CMP;
`ifndef DVSD_CMP_EARLY_EXIT_EN
          w_found_nxt    = 1'b0;
          w_res_nxt      = RES_EQ;
`endif
        end
      end
      CMP: begin
`ifdef DVSD_CMP_EARLY_EXIT_EN
        if (!w_eq || (r_idx == '0)) begin
`else
        if (!r_found && !w_eq) begin
          w_found_nxt = 1'b1;
          w_res_nxt   = w_res_cur;
        end
        if (r_idx == '0) begin
`endif
          w_lt_nxt        = (w_res_fin == RES_LT);
          w_eq_nxt        = (w_res_fin == RES_EQ);
          w_gt_nxt        = (w_res_fin == RES_GT);
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = DONE;
        end else begin
          w_idx_nxt = r_idx - IW'(1);
        end
      end
      DONE: begin
        if (r_out_valid && out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_lt_nxt        = 1'b0;
          w_eq_nxt        = 1'b0;
          w_gt_nxt        = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_in_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_lt        <= 1'b0;
      r_eq        <= 1'b0;
      r_gt        <= 1'b0;
`ifndef DVSD_CMP_EARLY_EXIT_EN
      r_found     <= 1'b0;
      r_res       <= RES_EQ;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_idx       <= w_idx_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_lt        <= w_lt_nxt;
      r_eq        <= w_eq_nxt;
      r_gt        <= w_gt_nxt;
`ifndef DVSD_CMP_EARLY_EXIT_EN
      r_found     <= w_found_nxt;
      r_res       <= w_res_nxt;
`endif
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign less_than    = r_lt;
  assign equal_to     = r_eq;
  assign greater_than = r_gt;

endmodule

// File: tb/tb_dvsd_cmp_iter.sv
// Scoreboard bench for dvsd_cmp_iter (WIDTH=16, CHUNK=4); latency expectations follow DVSD_CMP_EARLY_EXIT_EN.
module tb_dvsd_cmp_iter;

  localparam int NCHUNK = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A_in;
  logic [15:0] B_in;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic        less_than;
  logic        equal_to;
  logic        greater_than;
  logic [2:0]  flags;

  assign flags = {less_than, equal_to, greater_than};

  dvsd_cmp_iter #(.WIDTH(16), .CHUNK(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .A_in         (A_in),
    .B_in         (B_in),
    .signed_mode  (signed_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .less_than    (less_than),
    .equal_to     (equal_to),
    .greater_than (greater_than)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] fl;
    int         lat;
    int         acc;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input int j);
`ifdef DVSD_CMP_EARLY_EXIT_EN
    return j;
`else
    return (j > 0) ? NCHUNK : NCHUNK;
`endif
  endfunction

  // Called right after a falling edge; returns right after the falling edge following acceptance.
  task automatic send(input string nm, input logic [15:0] a, input logic [15:0] b,
                      input logic sm, input logic [2:0] fl, input int j, input bit push);
    int   n;
    exp_t e;
    n = 0;
    A_in = a; B_in = b; signed_mode = sm; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk({nm, " accept timeout"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      e.fl  = fl;
      e.lat = exp_lat(j);
      e.acc = cyc + 1;
      q.push_back(e);
      nq.push_back(nm);
    end
    @(negedge clk);
    in_valid    = 1'b0;
    signed_mode = ~sm;
    A_in        = ~a;
    chk({nm, " in_ready in CMP"}, 32'(in_ready), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: checks handshake behaviour every cycle and pops the scoreboard on each output handshake.
  logic       prev_ov, prev_hs, hold;
  logic [2:0] held;
  int         rise_cyc;
  initial begin
    prev_ov = 1'b0; prev_hs = 1'b0; hold = 1'b0; held = '0; rise_cyc = 0;
  end

  always begin
    exp_t  e;
    string nm;
    @(negedge clk);
    #1;
    if (rst) begin
      prev_ov = 1'b0; prev_hs = 1'b0; hold = 1'b0;
    end else begin
      if (prev_hs) begin
        chk("in_ready after handshake", 32'(in_ready), 32'd1);
        chk("out_valid after handshake", 32'(out_valid), 32'd0);
      end
      if (hold) begin
        chk("held out_valid", 32'(out_valid), 32'd1);
        chk("held flags", 32'(flags), 32'(held));
      end
      if (!out_valid) begin
        chk("flags while idle", 32'(flags), 32'd0);
      end else begin
        chk("in_ready in DONE", 32'(in_ready), 32'd0);
        if (!prev_ov) rise_cyc = cyc;
      end
      prev_hs = out_valid && out_ready;
      hold    = out_valid && !out_ready;
      held    = flags;
      if (prev_hs) begin
        if (q.size() == 0) begin
          chk("unexpected result", 32'(out_valid), 32'd0);
        end else begin
          e  = q.pop_front();
          nm = nq.pop_front();
          chk({nm, " flags"}, 32'(flags), 32'(e.fl));
          chk({nm, " latency"}, 32'(rise_cyc - e.acc), 32'(e.lat));
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A_in = '0; B_in = '0; signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // name, A, B, signed, {lt,eq,gt}, 1-based first differing chunk, push
    send("u_lt_lsb",  16'h1000, 16'h1001, 1'b0, 3'b100, 4, 1'b1);
    send("u_gt_msb",  16'hA0A0, 16'h20A0, 1'b0, 3'b001, 1, 1'b1);
    send("s_lt_min",  16'h8000, 16'h0001, 1'b1, 3'b100, 1, 1'b1);
    send("u_gt_8000", 16'h8000, 16'h0001, 1'b0, 3'b001, 1, 1'b1);
    send("s_lt_neg1", 16'hFFFF, 16'h0001, 1'b1, 3'b100, 1, 1'b1);
    send("s_gt_max",  16'h7FFF, 16'h8000, 1'b1, 3'b001, 1, 1'b1);
    send("u_lt_mid",  16'h1234, 16'h1243, 1'b0, 3'b100, 3, 1'b1);
    send("eq_ffff",   16'hFFFF, 16'hFFFF, 1'b0, 3'b010, 4, 1'b1);
    send("eq_0000",   16'h0000, 16'h0000, 1'b0, 3'b010, 4, 1'b1);
    send("s_eq",      16'h8001, 16'h8001, 1'b1, 3'b010, 4, 1'b1);
    wait_idle();

    // Backpressure: consumer stalls five result cycles, handshakes on the sixth.
    out_ready = 1'b0;
    send("bp_gt", 16'h0011, 16'h0010, 1'b0, 3'b001, 4, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp out_valid timeout", 32'(out_valid), 32'd1);
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    wait_idle();

    // Reset two edges after acceptance discards the in-flight compare.
    send("rst_op", 16'h1234, 16'h1235, 1'b0, 3'b100, 4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst flags", 32'(flags), 32'd0);
    repeat (6) @(negedge clk);
    send("post_rst_gt", 16'h0005, 16'h0003, 1'b0, 3'b001, 4, 1'b1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
